weight_writeback: RTL and testbench

Writes the trained weight vector back into the 12-bit weight block RAM after a training epoch completes. The trainer exposes its 784 signed 16-bit weights through a synchronous read port; this block sequences through them, converts each to the 12-bit stored-word format with saturation, and drives the BRAM write port. It is the write-side counterpart of the weight-loading path, so that the next epoch and later inference start from updated weights.

---
 rtl/weight_writeback_pkg.sv | 19 +
 rtl/weight_sat12.sv | 31 +++
 rtl/weight_writeback.sv | 130 +++++++++++++
 tb/tb_weight_writeback.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_writeback_pkg.sv
// Shared constants and FSM state type for the trained-weight write-back path.
package weight_writeback_pkg;

  localparam int N_WEIGHTS = 784;
  localparam int ADDR_W    = 10;
  localparam int IN_W      = 16;
  localparam int OUT_W     = 12;

  localparam int W_MAX     = 2047;
  localparam int W_MIN     = -2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } wb_state_e;

endpackage

// File: rtl/weight_sat12.sv
// Combinational signed IN_W -> OUT_W saturating converter; o_is_sat flags a clamp.
module weight_sat12 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 12
) (
  input  logic [IN_W-1:0]  i_w,
  output logic [OUT_W-1:0] o_w,
  output logic             o_is_sat
);
  import weight_writeback_pkg::*;

  localparam int LP_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int LP_MIN = -(1 << (OUT_W - 1));

  logic signed [IN_W-1:0] w_in;

  assign w_in = $signed(i_w);

  always_comb begin
    o_w      = i_w[OUT_W-1:0];
    o_is_sat = 1'b0;
    if (w_in > LP_MAX) begin
      o_w      = OUT_W'(LP_MAX);
      o_is_sat = 1'b1;
    end else if (w_in < LP_MIN) begin
      o_w      = OUT_W'(LP_MIN);
      o_is_sat = 1'b1;
    end
  end

endmodule

// File: rtl/weight_writeback.sv
// Streams trainer weights through a 3-stage pipeline into the 12-bit weight BRAM,
// counting saturated weights and accumulating a checksum of the written words.
module weight_writeback #(
  parameter int N_WEIGHTS = weight_writeback_pkg::N_WEIGHTS,
  parameter int ADDR_W    = weight_writeback_pkg::ADDR_W,
  parameter int IN_W      = weight_writeback_pkg::IN_W,
  parameter int OUT_W     = weight_writeback_pkg::OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [IN_W-1:0]   w_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [OUT_W-1:0]  bram_din,
  output logic [ADDR_W-1:0] sat_count,
  output logic [15:0]       checksum
);
  import weight_writeback_pkg::*;

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(N_WEIGHTS - 1);

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  logic              w_accept;
  logic              w_issue;

  logic [ADDR_W-1:0] r_rd_cnt;
  logic              r_s2_vld;
  logic [ADDR_W-1:0] r_s2_addr;
  logic              r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [OUT_W-1:0]  r_bram_din;
  logic [ADDR_W-1:0] r_sat_count;
  logic [15:0]       r_checksum;

  logic [OUT_W-1:0]  w_conv;
  logic              w_is_sat;
  logic [15:0]       w_din_sext;

  weight_sat12 #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .i_w      (w_data),
    .o_w      (w_conv),
    .o_is_sat (w_is_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_issue = 1'b1;
        if (r_rd_cnt == LP_LAST) w_state_nxt = ST_DRAIN;
      end
      // Leave DRAIN in the cycle the last write is on the BRAM port.
      ST_DRAIN: begin
        if (r_bram_we && (r_bram_addr == LP_LAST)) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_din_sext = {{(16 - OUT_W){r_bram_din[OUT_W-1]}}, r_bram_din};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt    <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_addr   <= '0;
      r_bram_we   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_sat_count <= '0;
      r_checksum  <= '0;
    end else begin
      r_s2_vld  <= w_issue;
      r_s2_addr <= r_rd_cnt;
      r_bram_we <= r_s2_vld;

      if (w_accept) begin
        r_rd_cnt <= '0;
      end else if (w_issue && (r_rd_cnt != LP_LAST)) begin
        r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
      end

      // w_data belongs to r_s2_addr: the source read port has one cycle of latency.
      if (r_s2_vld) begin
        r_bram_addr <= r_s2_addr;
        r_bram_din  <= w_conv;
      end

      if (w_accept) begin
        r_sat_count <= '0;
        r_checksum  <= '0;
      end else begin
        if (r_s2_vld && w_is_sat) r_sat_count <= r_sat_count + ADDR_W'(1);
        if (r_bram_we)            r_checksum  <= r_checksum + w_din_sext;
      end
    end
  end

  assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign w_addr    = r_rd_cnt;
  assign bram_we   = r_bram_we;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;
  assign sat_count = r_sat_count;
  assign checksum  = r_checksum;

endmodule

// File: tb/tb_weight_writeback.sv
// Scoreboard bench for weight_writeback: expected writes and done summaries are
// queued at stimulus time and popped by a negedge monitor.
module tb_weight_writeback;

  localparam int NW     = 784;
  localparam int ADDR_W = 10;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] w_addr;
  logic [IN_W-1:0]   w_data;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [OUT_W-1:0]  bram_din;
  logic [ADDR_W-1:0] sat_count;
  logic [15:0]       checksum;

  weight_writeback #(
    .N_WEIGHTS (NW),
    .ADDR_W    (ADDR_W),
    .IN_W      (IN_W),
    .OUT_W     (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .sat_count (sat_count),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [IN_W-1:0] src [NW];
  always @(posedge clk) w_data <= (int'(w_addr) < NW) ? src[w_addr] : '0;

  typedef struct { int addr; int din; } wr_t;
  typedef struct { int cyc; int sat; int chk; } done_t;
  wr_t   wr_q[$];
  done_t done_q[$];

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t   w;
    done_t d;
    if (bram_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("write_while_none_expected", 32'(bram_we), 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("bram_addr", 32'(bram_addr), 32'(w.addr));
        check("bram_din", 32'(bram_din), 32'(w.din));
      end
    end
    if (done === 1'b1) begin
      n_done++;
      if (done_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        d = done_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(d.cyc));
        check("sat_count", 32'(sat_count), 32'(d.sat));
        check("checksum", 32'(checksum), 32'(d.chk));
        check("writes_left_at_done", 32'(wr_q.size()), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic load_ramp();
    for (int i = 0; i < NW; i++) src[i] = 16'(i - 392);
  endtask

  task automatic load_sat();
    for (int i = 0; i < NW; i++) src[i] = '0;
    src[0] = 16'sh7FFF;
    src[1] = 16'sh8000;
    src[2] = 16'sd2047;
    src[3] = -16'sd2048;
  endtask

  task automatic expect_transfer(int t0);
    int          c;
    int          sat;
    logic [15:0] chk;
    sat = 0;
    chk = '0;
    for (int i = 0; i < NW; i++) begin
      c = int'(src[i]);
      if (c > 2047) begin
        c = 2047;
        sat++;
      end else if (c < -2048) begin
        c = -2048;
        sat++;
      end
      wr_q.push_back('{addr: i, din: c & 'hFFF});
      chk = chk + 16'(c);
    end
    done_q.push_back('{cyc: t0 + NW + 3, sat: sat, chk: int'(chk)});
  endtask

  task automatic issue_start(output int t0);
    start = 1'b1;
    t0    = cyc;
    expect_transfer(t0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("w_addr_after_start", 32'(w_addr), 32'd0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < NW + 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    check({tag, "_bram_we"}, 32'(bram_we), 32'd0);
    check({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
    check({tag, "_bram_din"}, 32'(bram_din), 32'd0);
    check({tag, "_sat_count"}, 32'(sat_count), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int nd;
    rst   = 1'b1;
    start = 1'b0;
    load_ramp();
    step(3);
    check_reset_vals("reset");
    rst = 1'b0;

    // Idle: no start, outputs keep reset values
    step(50);
    check_reset_vals("idle");

    // Ramp transfer: checksum of -392..391 is -392 = 16'hFE78
    load_ramp();
    issue_start(t0);
    wait_done();
    check("ramp_checksum_const", 32'(checksum), 32'h0000FE78);
    step(5);

    // Saturation pattern
    load_sat();
    issue_start(t0);
    wait_done();
    step(5);

    // Start while busy is ignored
    load_ramp();
    nd = n_done;
    issue_start(t0);
    while (cyc < t0 + 100) step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done();
    step(20);
    check("single_done_pulse", 32'(n_done - nd), 32'd1);

    // Reset mid-transfer
    issue_start(t0);
    while (cyc < t0 + 200) step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wr_q.delete();
    done_q.delete();
    check_reset_vals("midreset");
    step(5);
    issue_start(t0);
    wait_done();
    step(5);

    // Back-to-back: saturation run, start in done cycle ignored, next cycle accepted
    load_sat();
    issue_start(t0);
    wait_done();
    start = 1'b1;
    step(1);
    load_ramp();
    issue_start(t0);
    check("b2b_sat_cleared", 32'(sat_count), 32'd0);
    check("b2b_chk_cleared", 32'(checksum), 32'd0);
    wait_done();
    step(10);

    check("final_wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("final_done_q_empty", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
